// File: rtl/ddr_clear_pkg.sv
// Shared types and helpers for the DDR3 clear engine.
// Word addresses are 64-bit granular, 29 bits wide.
package ddr_clear_pkg;

  localparam int DDR_AW = 29;
  localparam int DDR_DW = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BEATS,
    S_DONE
  } state_e;

  function automatic logic [7:0] min_burst(
    input logic [DDR_AW-1:0] remaining,
    input int                burst_len
  );
    logic [DDR_AW-1:0] bl;
    bl = DDR_AW'(burst_len);
    return (remaining < bl) ? remaining[7:0] : bl[7:0];
  endfunction

endpackage

// File: rtl/ddr_clear_engine.sv
// Avalon-MM burst-write master filling a DDR3 region with FILL.
// Read side tied off; one FSM plus beat and word counters.
module ddr_clear_engine
  import ddr_clear_pkg::*;
#(
  parameter int                BURST_LEN = 128,
  parameter logic [DDR_DW-1:0] FILL      = 64'h0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DDR_AW-1:0] base_addr,
  input  logic [DDR_AW-1:0] len_words,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [DDR_AW-1:0] words_left,
  input  logic              DDRAM_BUSY,
  output logic [7:0]        DDRAM_BURSTCNT,
  output logic [DDR_AW-1:0] DDRAM_ADDR,
  output logic [DDR_DW-1:0] DDRAM_DIN,
  output logic [7:0]        DDRAM_BE,
  output logic              DDRAM_WE,
  output logic              DDRAM_RD
);

  state_e            state_q, state_d;
  logic [DDR_AW-1:0] addr_q, addr_d;
  logic [DDR_AW-1:0] ddr_addr_q, ddr_addr_d;
  logic [DDR_AW-1:0] words_left_q, words_left_d;
  logic [7:0]        burstcnt_q, burstcnt_d;
  logic [7:0]        beat_q, beat_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              abort_lat_q, abort_lat_d;
  logic [7:0]        next_cnt;

  assign next_cnt = min_burst(words_left_q, BURST_LEN);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    ddr_addr_d   = ddr_addr_q;
    words_left_d = words_left_q;
    burstcnt_d   = burstcnt_q;
    beat_d       = beat_q;
    we_d         = we_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    aborted_d    = aborted_q;
    abort_lat_d  = abort_lat_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d       = base_addr;
          words_left_d = len_words;
          aborted_d    = 1'b0;
          abort_lat_d  = 1'b0;
          if (len_words != '0) begin
            state_d = S_ISSUE;
            busy_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        abort_lat_d = abort_lat_q | abort;
        ddr_addr_d  = addr_q;
        burstcnt_d  = next_cnt;
        beat_d      = next_cnt;
        we_d        = 1'b1;
        state_d     = S_BEATS;
      end
      S_BEATS: begin
        abort_lat_d = abort_lat_q | abort;
        if (we_q) begin
          if (!DDRAM_BUSY) begin
            beat_d       = beat_q - 8'd1;
            words_left_d = words_left_q - 1'b1;
            if (beat_q == 8'd1) begin
              we_d   = 1'b0;
              addr_d = addr_q + DDR_AW'(burstcnt_q);
            end
          end
        // WE already dropped: burst finished, pick next step
        end else if (words_left_q == '0 || abort_lat_q) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          aborted_d = (words_left_q != '0);
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        abort_lat_d = 1'b0;
        aborted_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      ddr_addr_q   <= '0;
      words_left_q <= '0;
      burstcnt_q   <= '0;
      beat_q       <= '0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_lat_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      ddr_addr_q   <= ddr_addr_d;
      words_left_q <= words_left_d;
      burstcnt_q   <= burstcnt_d;
      beat_q       <= beat_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      abort_lat_q  <= abort_lat_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = aborted_q;
  assign words_left     = words_left_q;
  assign DDRAM_BURSTCNT = burstcnt_q;
  assign DDRAM_ADDR     = ddr_addr_q;
  assign DDRAM_DIN      = FILL;
  assign DDRAM_BE       = 8'hFF;
  assign DDRAM_WE       = we_q;
  assign DDRAM_RD       = 1'b0;

endmodule

// File: tb/tb_ddr_clear_engine.sv
// Directed bench for ddr_clear_engine (BURST_LEN 128 and 16).
// Both instances share inputs; sel picks the observed one.
module tb_ddr_clear_engine;

  localparam logic [63:0] FILLV = 64'hDEADBEEF_CAFEF00D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, abort, ddr_busy;
  logic [28:0] base, len;

  logic        a_busy, a_done, a_ab, a_we, a_rd;
  logic [28:0] a_wl, a_addr;
  logic [7:0]  a_cnt, a_be;
  logic [63:0] a_din;
  logic        b_busy, b_done, b_ab, b_we, b_rd;
  logic [28:0] b_wl, b_addr;
  logic [7:0]  b_cnt, b_be;
  logic [63:0] b_din;

  ddr_clear_engine #(.BURST_LEN(128), .FILL(FILLV)) dut (
    .clk_sys(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base), .len_words(len),
    .busy(a_busy), .done(a_done), .aborted(a_ab),
    .words_left(a_wl), .DDRAM_BUSY(ddr_busy),
    .DDRAM_BURSTCNT(a_cnt), .DDRAM_ADDR(a_addr),
    .DDRAM_DIN(a_din), .DDRAM_BE(a_be),
    .DDRAM_WE(a_we), .DDRAM_RD(a_rd)
  );

  ddr_clear_engine #(.BURST_LEN(16), .FILL(FILLV)) dut16 (
    .clk_sys(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base), .len_words(len),
    .busy(b_busy), .done(b_done), .aborted(b_ab),
    .words_left(b_wl), .DDRAM_BUSY(ddr_busy),
    .DDRAM_BURSTCNT(b_cnt), .DDRAM_ADDR(b_addr),
    .DDRAM_DIN(b_din), .DDRAM_BE(b_be),
    .DDRAM_WE(b_we), .DDRAM_RD(b_rd)
  );

  bit          sel;
  logic        o_busy, o_done, o_ab, o_we;
  logic [28:0] o_wl, o_addr;
  logic [7:0]  o_cnt;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_done = sel ? b_done : a_done;
  assign o_ab   = sel ? b_ab   : a_ab;
  assign o_we   = sel ? b_we   : a_we;
  assign o_wl   = sel ? b_wl   : a_wl;
  assign o_addr = sel ? b_addr : a_addr;
  assign o_cnt  = sel ? b_cnt  : a_cnt;

  int checks = 0;
  int failures = 0;

  int          r_done_cyc, r_beats, r_first_we;
  int          r_stable, r_mono, r_stalls;
  logic        r_ab, r_busy_done;
  logic [28:0] r_wl;
  logic [28:0] bq_addr[$];
  logic [7:0]  bq_cnt[$];

  task automatic run_job(
    input logic [28:0] b, input logic [28:0] l,
    input bit stall, input int abort_beat,
    input int reset_beat, input int restart_cyc,
    input bit do_rst
  );
    int          stall_left;
    int          stalled;
    bit          prev_we;
    logic [28:0] prev_wl, cur_a;
    logic [7:0]  cur_c;
    stall_left = 0; stalled = -1; prev_we = 0;
    cur_a = '0; cur_c = '0;
    r_done_cyc = -1; r_beats = 0; r_first_we = -1;
    r_stable = 0; r_mono = 0; r_stalls = 0;
    r_ab = 1'bx; r_wl = 'x; r_busy_done = 1'bx;
    bq_addr.delete(); bq_cnt.delete();
    if (do_rst) begin
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
    end
    @(negedge clk);
    base = b; len = l; start = 1'b1; prev_wl = l;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      start = (c == restart_cyc);
      base  = 29'h155;
      len   = 29'd9;
      if (stall_left > 0) begin
        ddr_busy = 1'b1; stall_left--;
      end else if (stall && o_we && r_beats % 5 == 4
                   && stalled != r_beats) begin
        stalled = r_beats; ddr_busy = 1'b1;
        stall_left = 2; r_stalls++;
      end else begin
        ddr_busy = 1'b0;
      end
      abort = (abort_beat > 0 && o_we
               && r_beats == abort_beat - 1);
      if (reset_beat > 0 && o_we
          && r_beats == reset_beat - 1) begin
        reset = 1'b1;
        break;
      end
      if (o_we && r_first_we < 0) r_first_we = c;
      if (o_we && !prev_we) begin
        bq_addr.push_back(o_addr);
        bq_cnt.push_back(o_cnt);
        cur_a = o_addr; cur_c = o_cnt;
      end else if (o_we && (o_addr !== cur_a || o_cnt !== cur_c)) begin
        r_stable++;
      end
      if (o_wl > prev_wl) r_mono++;
      prev_wl = o_wl;
      if (o_we && !ddr_busy) r_beats++;
      prev_we = o_we;
      if (o_done) begin
        r_done_cyc = c; r_ab = o_ab;
        r_wl = o_wl; r_busy_done = o_busy;
        break;
      end
    end
    start = 1'b0; abort = 1'b0; ddr_busy = 1'b0;
  endtask

  task automatic test_reset;
    sel = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_we !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl got busy=%b done=%b we=%b want 0", a_busy, a_done, a_we); end
    checks++; if (a_wl !== 29'd0 || a_addr !== 29'd0 || a_cnt !== 8'd0) begin
      failures++; $display("FAIL reset_regs got wl=%0d addr=%0h cnt=%0d want 0", a_wl, a_addr, a_cnt); end
    checks++; if (a_din !== FILLV || a_be !== 8'hFF || a_rd !== 1'b0) begin
      failures++; $display("FAIL reset_consts got din=%h be=%h rd=%b", a_din, a_be, a_rd); end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    sel = 0;
    run_job(29'd0, 29'd300, 0, -1, -1, 5, 1);
    checks++; if (r_done_cyc !== 307) begin
      failures++; $display("FAIL basic_done_cycle got=%0d want=307", r_done_cyc); end
    checks++; if (r_first_we !== 2) begin
      failures++; $display("FAIL basic_first_we got=%0d want=2", r_first_we); end
    checks++; if (r_beats !== 300) begin
      failures++; $display("FAIL basic_beats got=%0d want=300", r_beats); end
    checks++; if (bq_addr.size() !== 3) begin
      failures++; $display("FAIL basic_nbursts got=%0d want=3", bq_addr.size());
    end else if (bq_addr[0] !== 29'd0 || bq_cnt[0] !== 8'd128 ||
                 bq_addr[1] !== 29'd128 || bq_cnt[1] !== 8'd128 ||
                 bq_addr[2] !== 29'd256 || bq_cnt[2] !== 8'd44) begin
      failures++;
      $display("FAIL basic_bursts got (%0d,%0d)(%0d,%0d)(%0d,%0d) want (0,128)(128,128)(256,44)",
               bq_addr[0], bq_cnt[0], bq_addr[1], bq_cnt[1], bq_addr[2], bq_cnt[2]);
    end
    checks++; if (r_ab !== 1'b0 || r_wl !== 29'd0 || r_busy_done !== 1'b0) begin
      failures++; $display("FAIL basic_done_state got ab=%b wl=%0d busy=%b want 0,0,0", r_ab, r_wl, r_busy_done); end
    checks++; if (r_stable !== 0 || r_mono !== 0) begin
      failures++; $display("FAIL basic_stability got stable_err=%0d mono_err=%0d want 0", r_stable, r_mono); end
  endtask

  task automatic test_stall;
    sel = 0;
    run_job(29'd0, 29'd300, 1, -1, -1, 0, 1);
    checks++; if (r_beats !== 300) begin
      failures++; $display("FAIL stall_beats got=%0d want=300", r_beats); end
    checks++; if (r_stable !== 0 || bq_addr.size() !== 3) begin
      failures++; $display("FAIL stall_hold got stable_err=%0d bursts=%0d want 0,3", r_stable, bq_addr.size()); end
    checks++; if (r_stalls !== 60 || r_done_cyc !== 487) begin
      failures++; $display("FAIL stall_done got stalls=%0d cyc=%0d want 60,487", r_stalls, r_done_cyc); end
    checks++; if (r_ab !== 1'b0 || r_wl !== 29'd0) begin
      failures++; $display("FAIL stall_end got ab=%b wl=%0d want 0,0", r_ab, r_wl); end
  endtask

  task automatic test_back_to_back;
    sel = 0;
    run_job(29'd0, 29'd5, 0, -1, -1, 8, 1);
    checks++; if (r_done_cyc !== 8) begin
      failures++; $display("FAIL b2b_done1 got=%0d want=8", r_done_cyc); end
    @(negedge clk);
    checks++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_we !== 1'b0) begin
      failures++; $display("FAIL b2b_ignored got busy=%b done=%b we=%b want 0", a_busy, a_done, a_we); end
    run_job(29'd100, 29'd3, 0, -1, -1, 0, 0);
    checks++; if (r_done_cyc !== 6 || bq_addr.size() !== 1) begin
      failures++; $display("FAIL b2b_job2 got cyc=%0d bursts=%0d want 6,1", r_done_cyc, bq_addr.size());
    end else if (bq_addr[0] !== 29'd100 || bq_cnt[0] !== 8'd3) begin
      failures++; $display("FAIL b2b_burst got (%0d,%0d) want (100,3)", bq_addr[0], bq_cnt[0]);
    end
  endtask

  task automatic test_wrap;
    sel = 1;
    run_job(29'h1FFFFFF0, 29'd32, 0, -1, -1, 0, 1);
    checks++; if (bq_addr.size() !== 2) begin
      failures++; $display("FAIL wrap_nbursts got=%0d want=2", bq_addr.size());
    end else if (bq_addr[0] !== 29'h1FFFFFF0 || bq_cnt[0] !== 8'd16 ||
                 bq_addr[1] !== 29'd0 || bq_cnt[1] !== 8'd16) begin
      failures++; $display("FAIL wrap_bursts got (%h,%0d)(%h,%0d) want (1ffffff0,16)(0,16)",
                           bq_addr[0], bq_cnt[0], bq_addr[1], bq_cnt[1]);
    end
    checks++; if (r_done_cyc !== 37 || r_wl !== 29'd0 || r_ab !== 1'b0) begin
      failures++; $display("FAIL wrap_done got cyc=%0d wl=%0d ab=%b want 37,0,0", r_done_cyc, r_wl, r_ab); end
    sel = 0;
  endtask

  task automatic test_abort;
    sel = 0;
    run_job(29'd0, 29'd1000, 0, 10, -1, 0, 1);
    checks++; if (r_beats !== 128 || bq_addr.size() !== 1) begin
      failures++; $display("FAIL abort_beats got beats=%0d bursts=%0d want 128,1", r_beats, bq_addr.size()); end
    checks++; if (r_ab !== 1'b1 || r_wl !== 29'd872) begin
      failures++; $display("FAIL abort_done got ab=%b wl=%0d want 1,872", r_ab, r_wl); end
    checks++; if (r_done_cyc !== 131) begin
      failures++; $display("FAIL abort_cycle got=%0d want=131", r_done_cyc); end
  endtask

  task automatic test_zero;
    sel = 0;
    run_job(29'd40, 29'd0, 0, -1, -1, 0, 1);
    checks++; if (r_done_cyc !== 1 || r_first_we !== -1) begin
      failures++; $display("FAIL zero_len got cyc=%0d first_we=%0d want 1,-1", r_done_cyc, r_first_we); end
    checks++; if (r_ab !== 1'b0 || r_wl !== 29'd0) begin
      failures++; $display("FAIL zero_done got ab=%b wl=%0d want 0,0", r_ab, r_wl); end
  endtask

  task automatic test_reset_mid;
    sel = 0;
    run_job(29'd0, 29'd300, 0, -1, 50, 0, 1);
    @(negedge clk);
    checks++; if (a_we !== 1'b0 || a_busy !== 1'b0 || a_wl !== 29'd0) begin
      failures++; $display("FAIL rstmid_state got we=%b busy=%b wl=%0d want 0,0,0", a_we, a_busy, a_wl); end
    checks++; if (a_addr !== 29'd0 || a_cnt !== 8'd0) begin
      failures++; $display("FAIL rstmid_regs got addr=%0d cnt=%0d want 0,0", a_addr, a_cnt); end
    reset = 1'b0;
    run_job(29'd0, 29'd20, 0, -1, -1, 0, 0);
    checks++; if (r_done_cyc !== 23 || r_beats !== 20 || r_ab !== 1'b0) begin
      failures++; $display("FAIL rstmid_rerun got cyc=%0d beats=%0d ab=%b want 23,20,0", r_done_cyc, r_beats, r_ab); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; ddr_busy = 1'b0;
    base = '0; len = '0; sel = 0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_wrap();
    test_abort();
    test_zero();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
